// File: rtl/run_control_unit_if.sv
// run_control_unit_if -- request, breakpoint-programming and status bundle
// for run_control_unit. The master side is the host/debugger, the slave side is the controller.
interface run_control_unit_if #(
    parameter int NB_PC    = 32,
    parameter int NB_BKPT  = 4,
    parameter int NB_STEP  = 8,
    parameter int NB_CYCLE = 32,
    parameter int NB_STATE = 3
);
    localparam int NB_IDX = (NB_BKPT > 1) ? $clog2(NB_BKPT) : 1;

    logic                i_run_req;
    logic                i_step_req;
    logic [NB_STEP-1:0]  i_step_count;
    logic                i_halt_req;
    logic                i_clear;
    logic                i_hlt;
    logic [NB_PC-1:0]    i_pc;
    logic                i_bp_wr;
    logic [NB_IDX-1:0]   i_bp_idx;
    logic [NB_PC-1:0]    i_bp_addr;
    logic                i_bp_valid;

    logic                o_dp_enable;
    logic [NB_STATE-1:0] o_state;
    logic                o_busy;
    logic                o_done;
    logic                o_bp_hit;
    logic [NB_IDX-1:0]   o_bp_idx;
    logic [NB_CYCLE-1:0] o_cycle_count;
    logic [NB_STEP-1:0]  o_step_remaining;

    modport master (
        output i_run_req, i_step_req, i_step_count, i_halt_req, i_clear, i_hlt, i_pc,
               i_bp_wr, i_bp_idx, i_bp_addr, i_bp_valid,
        input  o_dp_enable, o_state, o_busy, o_done, o_bp_hit, o_bp_idx,
               o_cycle_count, o_step_remaining
    );

    modport slave (
        input  i_run_req, i_step_req, i_step_count, i_halt_req, i_clear, i_hlt, i_pc,
               i_bp_wr, i_bp_idx, i_bp_addr, i_bp_valid,
        output o_dp_enable, o_state, o_busy, o_done, o_bp_hit, o_bp_idx,
               o_cycle_count, o_step_remaining
    );
endinterface

// File: rtl/run_control_unit.sv
// run_control_unit -- run / step-burst / halt sequencer that gates the datapath
// through a clock enable (o_dp_enable), never through a derived clock.
// Breakpoint slots and comparators are built only when RUN_CTRL_BKPT_EN is defined;
// otherwise the bp inputs are ignored and BREAK is reachable only by host abort.
//
// state   | meaning
// IDLE    | stopped, accepts run/step requests
// RUN     | free-running, datapath enabled
// STEP    | burst of o_step_remaining enabled cycles
// HALTED  | halt instruction retired; only i_clear leaves
// BREAK   | stopped by breakpoint or host abort; run/step resumes
module run_control_unit #(
    parameter int NB_PC    = 32,
    parameter int NB_BKPT  = 4,
    parameter int NB_STEP  = 8,
    parameter int NB_CYCLE = 32,
    parameter int NB_STATE = 3
) (
    input  logic               i_clock,
    input  logic               i_reset,
    run_control_unit_if.slave  bus
);
    localparam int NB_IDX = (NB_BKPT > 1) ? $clog2(NB_BKPT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_BREAK  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_live;
    logic                r_first;
    logic                r_done;
    logic                r_bp_hit;
    logic [NB_IDX-1:0]   r_bp_idx;
    logic [NB_CYCLE-1:0] r_cycle;
    logic [NB_STEP-1:0]  r_rem;

    logic                w_busy;
    logic                w_match_any;
    logic [NB_IDX-1:0]   w_match_idx;
    logic                w_bp_stop;
    logic                w_enable;
    logic [NB_STEP-1:0]  w_step_load;

`ifdef RUN_CTRL_BKPT_EN
    logic [NB_PC-1:0]    r_bp_addr [NB_BKPT];
    logic [NB_BKPT-1:0]  r_bp_valid;

    // Slot programming; a written slot starts comparing on the following cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_bp_valid <= '0;
            for (int k = 0; k < NB_BKPT; k++) r_bp_addr[k] <= '0;
        end else if (bus.i_bp_wr && (int'(bus.i_bp_idx) < NB_BKPT)) begin
            r_bp_valid[bus.i_bp_idx] <= bus.i_bp_valid;
            r_bp_addr[bus.i_bp_idx]  <= bus.i_bp_addr;
        end
    end

    // Compare every valid slot with the next-fetch PC; descending scan leaves the lowest hit.
    always_comb begin
        w_match_any = 1'b0;
        w_match_idx = '0;
        for (int k = NB_BKPT - 1; k >= 0; k--) begin
            if (r_bp_valid[k] && (r_bp_addr[k] == bus.i_pc)) begin
                w_match_any = 1'b1;
                w_match_idx = NB_IDX'(k);
            end
        end
    end
`else
    logic             w_unused_bp;
    logic [NB_PC-1:0] w_unused_pc;
    assign w_unused_pc = bus.i_pc ^ bus.i_bp_addr;
    assign w_unused_bp = ^{bus.i_bp_wr, bus.i_bp_idx, bus.i_bp_valid, w_unused_pc};
    assign w_match_any = 1'b0;
    assign w_match_idx = '0;
`endif

    assign w_busy      = (r_state == ST_RUN) || (r_state == ST_STEP);
    // The first enabled cycle after entry skips matching so a resume moves off the break PC.
    assign w_bp_stop   = w_busy && !r_first && w_match_any;
    assign w_enable    = w_busy && !w_bp_stop && !bus.i_halt_req;
    assign w_step_load = (bus.i_step_count == '0) ? NB_STEP'(1) : bus.i_step_count;

    assign bus.o_dp_enable      = w_enable;
    assign bus.o_state          = NB_STATE'(r_state);
    assign bus.o_busy           = w_busy;
    assign bus.o_done           = r_done;
    assign bus.o_bp_hit         = r_bp_hit;
    assign bus.o_bp_idx         = r_bp_idx;
    assign bus.o_cycle_count    = r_cycle;
    assign bus.o_step_remaining = r_rem;

    // Sequencer: state transitions by priority, stop reporting, burst remainder and cycle count.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_first  <= 1'b0;
            r_done   <= 1'b0;
            r_bp_hit <= 1'b0;
            r_bp_idx <= '0;
            r_cycle  <= '0;
            r_rem    <= '0;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            if (w_enable) begin
                r_first <= 1'b0;
                if (r_cycle != {NB_CYCLE{1'b1}}) r_cycle <= r_cycle + NB_CYCLE'(1);
                if (r_state == ST_STEP) r_rem <= r_rem - NB_STEP'(1);
            end
            // r_live is low only on the release edge, where no request is taken.
            if (r_live) begin
                if (bus.i_clear) begin
                    r_state  <= ST_IDLE;
                    r_rem    <= '0;
                    r_bp_hit <= 1'b0;
                    r_cycle  <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE, ST_BREAK: begin
                            if (bus.i_run_req || bus.i_step_req) begin
                                r_first <= 1'b1;
                                if (r_state == ST_IDLE) r_cycle <= '0;
                                if (bus.i_run_req) begin
                                    r_state <= ST_RUN;
                                end else begin
                                    r_state <= ST_STEP;
                                    r_rem   <= w_step_load;
                                end
                            end
                        end
                        ST_RUN, ST_STEP: begin
                            if (bus.i_hlt) begin
                                r_state  <= ST_HALTED;
                                r_done   <= 1'b1;
                                r_bp_hit <= 1'b0;
                            end else if (w_bp_stop) begin
                                r_state  <= ST_BREAK;
                                r_done   <= 1'b1;
                                r_bp_hit <= 1'b1;
                                r_bp_idx <= w_match_idx;
                            end else if (bus.i_halt_req) begin
                                r_state  <= ST_BREAK;
                                r_done   <= 1'b1;
                                r_bp_hit <= 1'b0;
                            end else if ((r_state == ST_STEP) && w_enable && (r_rem == NB_STEP'(1))) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_run_control_unit.sv
// tb_run_control_unit -- directed vector table, hand-written corner sequences and
// random stimulus against a rule-level reference model. A second instance with a
// 4-bit cycle counter shares the stimulus to exercise counter saturation.
module tb_run_control_unit;
`ifdef RUN_CTRL_BKPT_EN
    localparam bit BKPT_EN = 1'b1;
`else
    localparam bit BKPT_EN = 1'b0;
`endif
    localparam int NBK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    run_control_unit_if #(.NB_CYCLE(32)) bus ();
    run_control_unit_if #(.NB_CYCLE(4))  bus4 ();

    assign bus4.i_run_req    = bus.i_run_req;
    assign bus4.i_step_req   = bus.i_step_req;
    assign bus4.i_step_count = bus.i_step_count;
    assign bus4.i_halt_req   = bus.i_halt_req;
    assign bus4.i_clear      = bus.i_clear;
    assign bus4.i_hlt        = bus.i_hlt;
    assign bus4.i_pc         = bus.i_pc;
    assign bus4.i_bp_wr      = bus.i_bp_wr;
    assign bus4.i_bp_idx     = bus.i_bp_idx;
    assign bus4.i_bp_addr    = bus.i_bp_addr;
    assign bus4.i_bp_valid   = bus.i_bp_valid;

    run_control_unit #(.NB_CYCLE(32)) dut  (.i_clock(clk), .i_reset(rst_n), .bus(bus));
    run_control_unit #(.NB_CYCLE(4))  dut4 (.i_clock(clk), .i_reset(rst_n), .bus(bus4));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit run; bit step; int cnt; bit halt; bit clr; bit hlt;
        int st; bit en; bit done; int cyc; int rem;
    } vec_t;
    vec_t tbl[17];
    vec_t none;

    // Reference model: state codes 0 IDLE, 1 RUN, 2 STEP, 3 HALTED, 4 BREAK.
    int          m_state, m_idx, m_rem, e_match;
    bit          m_first, m_live, m_done, m_hit, e_en, auto_pc;
    longint      m_cyc, m_cyc4;
    logic [31:0] m_bpa [NBK];
    bit          m_bpv [NBK];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_rem = 0; m_first = 0; m_live = 0; m_done = 0; m_hit = 0;
        m_cyc = 0; m_cyc4 = 0;
        for (int k = 0; k < NBK; k++) begin m_bpa[k] = '0; m_bpv[k] = 0; end
    endtask

    task automatic model_comb();
        bit busy;
        busy = (m_state == 1) || (m_state == 2);
        e_match = -1;
        if (BKPT_EN && busy && !m_first)
            for (int k = 0; k < NBK; k++)
                if (e_match < 0 && m_bpv[k] && m_bpa[k] == bus.i_pc) e_match = k;
        e_en = busy && (e_match < 0) && !bus.i_halt_req;
    endtask

    task automatic model_update();
        int st, rem0;
        bit nd;
        st = m_state; rem0 = m_rem; nd = 0;
        if (BKPT_EN && bus.i_bp_wr && int'(bus.i_bp_idx) < NBK) begin
            m_bpa[bus.i_bp_idx] = bus.i_bp_addr;
            m_bpv[bus.i_bp_idx] = bus.i_bp_valid;
        end
        if (!m_live) begin
            m_live = 1; m_done = 0;
            return;
        end
        if (e_en) begin
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (m_cyc4 < 15) m_cyc4++;
            m_first = 0;
            if (st == 2) m_rem = m_rem - 1;
        end
        if (bus.i_clear) begin
            m_state = 0; m_rem = 0; m_hit = 0; m_cyc = 0; m_cyc4 = 0;
        end else if (st == 0 || st == 4) begin
            if (bus.i_run_req || bus.i_step_req) begin
                if (st == 0) begin m_cyc = 0; m_cyc4 = 0; end
                m_first = 1;
                if (bus.i_run_req) m_state = 1;
                else begin
                    m_state = 2;
                    m_rem = (bus.i_step_count == 0) ? 1 : int'(bus.i_step_count);
                end
            end
        end else if (st == 1 || st == 2) begin
            if (bus.i_hlt) begin m_state = 3; nd = 1; m_hit = 0; end
            else if (e_match >= 0) begin m_state = 4; nd = 1; m_hit = 1; m_idx = e_match; end
            else if (bus.i_halt_req) begin m_state = 4; nd = 1; m_hit = 0; end
            else if (st == 2 && e_en && rem0 == 1) begin m_state = 0; nd = 1; end
        end
        m_done = nd;
    endtask

    task automatic tick_row(input bit use_row, input vec_t row);
        logic en_seen;
        @(negedge clk);
        model_comb();
        chk("state",      64'(bus.o_state),          64'(m_state));
        chk("dp_enable",  64'(bus.o_dp_enable),      64'(e_en));
        chk("busy",       64'(bus.o_busy),           64'(m_state == 1 || m_state == 2));
        chk("done",       64'(bus.o_done),           64'(m_done));
        chk("bp_hit",     64'(bus.o_bp_hit),         64'(m_hit));
        chk("bp_idx",     64'(bus.o_bp_idx),         64'(m_idx));
        chk("cycle",      64'(bus.o_cycle_count),    64'(m_cyc));
        chk("step_rem",   64'(bus.o_step_remaining), 64'(m_rem));
        chk("cycle4",     64'(bus4.o_cycle_count),   64'(m_cyc4));
        if (use_row) begin
            chk("vec_state",  64'(bus.o_state),          64'(row.st));
            chk("vec_enable", 64'(bus.o_dp_enable),      64'(row.en));
            chk("vec_done",   64'(bus.o_done),           64'(row.done));
            chk("vec_cycle",  64'(bus.o_cycle_count),    64'(row.cyc));
            chk("vec_rem",    64'(bus.o_step_remaining), 64'(row.rem));
        end
        en_seen = bus.o_dp_enable;
        @(posedge clk);
        model_update();
        #1;
        bus.i_run_req = 0; bus.i_step_req = 0; bus.i_halt_req = 0;
        bus.i_clear = 0; bus.i_hlt = 0; bus.i_bp_wr = 0;
        if (auto_pc && en_seen === 1'b1) bus.i_pc = bus.i_pc + 32'd4;
    endtask

    task automatic tick();
        tick_row(1'b0, none);
    endtask

    function automatic vec_t mkv(bit run, bit step, int cnt, bit halt, bit clr, bit hlt,
                                 int st, bit en, bit done, int cyc, int rem);
        vec_t v;
        v.run = run; v.step = step; v.cnt = cnt; v.halt = halt; v.clr = clr; v.hlt = hlt;
        v.st = st; v.en = en; v.done = done; v.cyc = cyc; v.rem = rem;
        return v;
    endfunction

    initial begin
        //              run step cnt halt clr hlt | st en done cyc rem
        tbl[0]  = mkv(0, 1, 3, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 3);
        tbl[2]  = mkv(0, 0, 0, 0, 0, 0,  2, 1, 0, 1, 2);
        tbl[3]  = mkv(0, 0, 0, 0, 0, 0,  2, 1, 0, 2, 1);
        tbl[4]  = mkv(1, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0);
        tbl[5]  = mkv(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
        tbl[6]  = mkv(0, 0, 0, 1, 0, 0,  1, 0, 0, 1, 0);
        tbl[7]  = mkv(0, 1, 0, 0, 0, 0,  4, 0, 1, 1, 0);
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0,  2, 1, 0, 1, 1);
        tbl[9]  = mkv(1, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0);
        tbl[10] = mkv(0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0);
        tbl[11] = mkv(1, 0, 0, 0, 0, 0,  3, 0, 1, 1, 0);
        tbl[12] = mkv(0, 1, 4, 0, 0, 0,  3, 0, 0, 1, 0);
        tbl[13] = mkv(0, 0, 0, 0, 1, 0,  3, 0, 0, 1, 0);
        tbl[14] = mkv(1, 1, 5, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[15] = mkv(0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0);
        tbl[16] = mkv(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        none = tbl[16];

        bus.i_run_req = 0; bus.i_step_req = 0; bus.i_step_count = '0; bus.i_halt_req = 0;
        bus.i_clear = 0; bus.i_hlt = 0; bus.i_pc = '0; bus.i_bp_wr = 0; bus.i_bp_idx = '0;
        bus.i_bp_addr = '0; bus.i_bp_valid = 0;
        auto_pc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // Directed vector table.
        for (int r = 0; r < 17; r++) begin
            bus.i_run_req = tbl[r].run; bus.i_step_req = tbl[r].step;
            bus.i_step_count = 8'(tbl[r].cnt); bus.i_halt_req = tbl[r].halt;
            bus.i_clear = tbl[r].clr; bus.i_hlt = tbl[r].hlt;
            tick_row(1'b1, tbl[r]);
        end

        // Randomized traffic against the model.
        auto_pc = 1;
        for (int c = 0; c < 600; c++) begin
            bus.i_run_req    = ($urandom_range(0, 7) == 0);
            bus.i_step_req   = ($urandom_range(0, 7) == 0);
            bus.i_step_count = 8'($urandom_range(0, 5));
            bus.i_halt_req   = ($urandom_range(0, 24) == 0);
            bus.i_clear      = ($urandom_range(0, 39) == 0);
            bus.i_hlt        = ($urandom_range(0, 29) == 0);
            bus.i_bp_wr      = ($urandom_range(0, 9) == 0);
            bus.i_bp_idx     = 2'($urandom_range(0, 3));
            bus.i_bp_addr    = 32'($urandom_range(0, 7) * 4);
            bus.i_bp_valid   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) bus.i_pc = 32'($urandom_range(0, 7) * 4);
            tick();
        end

        // Breakpoint at 0x10 in slots 1 and 3, run into it, then resume past it.
        auto_pc = 0;
        bus.i_clear = 1; tick();
        for (int k = 0; k < NBK; k++) begin
            bus.i_bp_wr = 1; bus.i_bp_idx = 2'(k); bus.i_bp_addr = 32'h10;
            bus.i_bp_valid = (k == 1 || k == 3);
            tick();
        end
        bus.i_pc = '0; auto_pc = 1;
        bus.i_run_req = 1; tick();
        repeat (6) tick();
        chk("bp_stop_state", 64'(bus.o_state),  BKPT_EN ? 64'd4 : 64'd1);
        chk("bp_stop_hit",   64'(bus.o_bp_hit), BKPT_EN ? 64'd1 : 64'd0);
        chk("bp_stop_idx",   64'(bus.o_bp_idx), BKPT_EN ? 64'd1 : 64'd0);
        chk("bp_stop_pc",    64'(bus.i_pc),     BKPT_EN ? 64'h10 : 64'h18);
        bus.i_run_req = 1; tick();
        tick(); tick();
        chk("resume_state", 64'(bus.o_state), 64'd1);
        chk("resume_pc",    64'(bus.i_pc),    BKPT_EN ? 64'h18 : 64'h24);

        // Halt instruction coinciding with a breakpoint match.
        bus.i_clear = 1; tick();
        bus.i_pc = 32'h0C; auto_pc = 1;
        bus.i_run_req = 1; tick();
        tick();
        bus.i_hlt = 1; tick();
        chk("hlt_state", 64'(bus.o_state),  64'd3);
        chk("hlt_hit",   64'(bus.o_bp_hit), 64'd0);
        chk("hlt_pc",    64'(bus.i_pc),     BKPT_EN ? 64'h10 : 64'h14);
        bus.i_run_req = 1; tick();
        bus.i_step_req = 1; bus.i_step_count = 8'd2; tick();
        tick();
        chk("halted_sticky", 64'(bus.o_state), 64'd3);
        bus.i_clear = 1; tick();
        tick();
        chk("halted_clear", 64'(bus.o_state), 64'd0);

        // 20-cycle run: the 4-bit counter saturates at 15.
        auto_pc = 0; bus.i_pc = 32'h200;
        bus.i_run_req = 1; tick();
        repeat (20) tick();
        chk("sat4_count",  64'(bus4.o_cycle_count), 64'd15);
        chk("cyc32_count", 64'(bus.o_cycle_count),  64'd20);
        bus.i_halt_req = 1; tick();
        bus.i_clear = 1; tick();

        // Asynchronous reset in the middle of a step burst.
        bus.i_pc = 32'h300;
        bus.i_step_req = 1; bus.i_step_count = 8'd8; tick();
        repeat (3) tick();
        chk("mid_rem",   64'(bus.o_step_remaining), 64'd5);
        chk("mid_state", 64'(bus.o_state),          64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state",  64'(bus.o_state),          64'd0);
        chk("async_enable", 64'(bus.o_dp_enable),      64'd0);
        chk("async_busy",   64'(bus.o_busy),           64'd0);
        chk("async_done",   64'(bus.o_done),           64'd0);
        chk("async_hit",    64'(bus.o_bp_hit),         64'd0);
        chk("async_idx",    64'(bus.o_bp_idx),         64'd0);
        chk("async_cycle",  64'(bus.o_cycle_count),    64'd0);
        chk("async_rem",    64'(bus.o_step_remaining), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_run_req = 1; tick();
        chk("release_ignored", 64'(bus.o_state), 64'd0);
        bus.i_run_req = 1; tick();
        chk("after_release_run", 64'(bus.o_state), 64'd1);
        bus.i_pc = 32'h10;
        tick(); tick();
        chk("slots_cleared_run", 64'(bus.o_state), 64'd1);
        bus.i_halt_req = 1; tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
